// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-fetch cache.
//   IDX_W / LINES : default geometry (16 direct-mapped one-word lines)
//   ADDR_W/DATA_W : default fetch address and instruction widths
//   state_e       : refill FSM encoding (IDLE, REQ)
//   ZERO_WORD     : word returned to the core when nothing valid is
//                   available; it decodes as a NOP downstream.
package icache_pkg;

  localparam int IDX_W  = 4;
  localparam int LINES  = 1 << IDX_W;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/icache_tagram.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
//   clk, rst          : clock, asynchronous active-low reset (clears valid only)
//   flush_i           : clears every valid bit at the clock edge; beats a write
//   rd_idx_i/rd_tag_i : combinational lookup; rd_hit_o/rd_data_o return result
//   wr_en_i           : fill strobe writing wr_tag_i/wr_data_i at wr_idx_i
module icache_tagram #(
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 26,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [TAG_W-1:0]  rd_tag_i,
  output logic              rd_hit_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [DATA_W-1:0] data_arr [LINES];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = '0;
    end else if (wr_en_i) begin
      valid_d[wr_idx_i] = 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // flops sample their inputs from before the edge, regardless of ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // NOTE: the tag/data arrays carry no reset; the valid bits alone decide
  // whether their contents are meaningful, and leaving them unreset lets
  // them map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_arr[wr_idx_i]  <= wr_tag_i;
      data_arr[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_hit_o  = valid_q[rd_idx_i] && (tag_arr[rd_idx_i] == rd_tag_i);
  assign rd_data_o = data_arr[rd_idx_i];

endmodule

// File: rtl/icache_fetch.sv
// Instruction-fetch front end placed directly ahead of the core.
//   clk, rst       : clock, asynchronous active-low reset
//   pc_i, ce_i     : fetch address and fetch enable from the core
//   flush_i        : one-cycle pulse invalidating every line
//   inst_o         : instruction to the core (zero when no hit)
//   stall_req_o    : holds PC/IF-ID while the current fetch misses
//   mem_req_o      : read request to instruction memory, held until ack
//   mem_addr_o     : word-aligned read address, held until ack
//   mem_ack_i      : read completion, mem_rdata_i valid in the same cycle
// A miss in IDLE latches the word address and raises the request the next
// cycle. At most one request is ever outstanding. A flush during a refill
// marks the pending fill as dead so stale data never becomes valid.
module icache_fetch #(
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              stall_req_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  import icache_pkg::*;

  localparam int TAG_W = ADDR_W - IDX_W - 2;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              pend_kill_q, pend_kill_d;

  logic              rd_hit;
  logic [DATA_W-1:0] rd_data;
  logic              hit;
  logic              wr_en;

  // The byte offset never selects anything in a one-word-per-line cache.
  logic unused_pc_bits;
  assign unused_pc_bits = ^pc_i[1:0];

  icache_tagram #(
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_tagram (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush_i),
    .rd_idx_i  (pc_i[IDX_W+1:2]),
    .rd_tag_i  (pc_i[ADDR_W-1:IDX_W+2]),
    .rd_hit_o  (rd_hit),
    .rd_data_o (rd_data),
    .wr_en_i   (wr_en),
    .wr_idx_i  (pend_addr_q[IDX_W+1:2]),
    .wr_tag_i  (pend_addr_q[ADDR_W-1:IDX_W+2]),
    .wr_data_i (mem_rdata_i)
  );

  assign hit    = ce_i && rd_hit;
  assign inst_o = hit ? rd_data : DATA_W'(ZERO_WORD);
  // Gating with rst keeps the stall low while reset is asserted even though
  // the (cleared) cache would otherwise report a miss.
  assign stall_req_o = rst && ce_i && !hit;

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_kill_d = pend_kill_q;
    wr_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A flush in the same cycle defers the miss; the cleared cache is
        // looked up again next cycle.
        if (ce_i && !hit && !flush_i) begin
          state_d     = REQ;
          pend_addr_d = {pc_i[ADDR_W-1:2], 2'b00};
        end
      end
      REQ: begin
        if (flush_i) begin
          pend_kill_d = 1'b1;
        end
        if (mem_ack_i) begin
          // The fill is dropped if a flush landed earlier in this refill
          // or lands on the ack cycle itself.
          wr_en       = !pend_kill_q && !flush_i;
          pend_kill_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pend_addr_q <= '0;
      pend_kill_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_kill_q <= pend_kill_d;
    end
  end

  // Request and address come straight from flops, so both are stable for
  // the whole refill and drop to zero the instant reset asserts.
  assign mem_req_o  = (state_q == REQ);
  assign mem_addr_o = pend_addr_q;

endmodule

// File: tb/tb_icache_fetch.sv
// Directed self-checking bench for icache_fetch. Inputs change 1 ns after
// the rising edge; outputs are sampled 3 ns after it.
module tb_icache_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic        flush_i;
  logic [31:0] inst_o;
  logic        stall_req_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int n_tests = 0;
  int n_fail  = 0;

  icache_fetch #(
    .IDX_W  (4),
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_i        (pc_i),
    .ce_i        (ce_i),
    .flush_i     (flush_i),
    .inst_o      (inst_o),
    .stall_req_o (stall_req_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] inst, input logic stall,
                      input logic req);
    check({tag, "_inst"},  inst_o,      inst);
    check({tag, "_stall"}, stall_req_o, 32'(stall));
    check({tag, "_req"},   mem_req_o,   32'(req));
  endtask

  // Starts a miss on address a in the current (IDLE) cycle, acks n cycles
  // after the miss with data d, then checks the hit in the following cycle.
  task automatic fill(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input int n);
    logic [31:0] waddr;
    waddr = {a[31:2], 2'b00};
    pc_i = a;
    ce_i = 1'b1;
    #2;
    look({tag, "_c0"}, 32'h0, 1'b1, 1'b0);
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i == n) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = d;
      end
      #2;
      check({tag, "_req"},   mem_req_o,   32'h1);
      check({tag, "_addr"},  mem_addr_o,  waddr);
      check({tag, "_stall"}, stall_req_o, 32'h1);
    end
    tick();
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    #2;
    look({tag, "_hit"}, d, 1'b0, 1'b0);
  endtask

  logic [31:0] hit_pc   [4];
  logic [31:0] hit_data [4];

  initial begin
    rst         = 1'b1;
    ce_i        = 1'b1;
    pc_i        = 32'h0;
    flush_i     = 1'b0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'h0;
    #1 rst = 1'b0;
    #2;
    look("reset", 32'h0, 1'b0, 1'b0);
    check("reset_addr", mem_addr_o, 32'h0);

    // Cold miss: release in cycle 0, ack in cycle 3, hit in cycle 4.
    tick();
    tick();
    rst = 1'b1;
    fill("cold", 32'h0000_0000, 32'h3401_1100, 3);

    // Minimum-penalty fill and a fill with unaligned low pc bits.
    tick();
    fill("w4", 32'h0000_0004, 32'h2402_0004, 1);
    tick();
    fill("w8", 32'h0000_000B, 32'h2403_0008, 2);

    // Hit stream, including a pc with nonzero byte offset.
    hit_pc   = '{32'h0, 32'h4, 32'h8, 32'h6};
    hit_data = '{32'h3401_1100, 32'h2402_0004, 32'h2403_0008, 32'h2402_0004};
    for (int i = 0; i < 4; i++) begin
      tick();
      pc_i = hit_pc[i];
      #2;
      look("stream", hit_data[i], 1'b0, 1'b0);
    end

    // Conflict eviction on index 0.
    tick();
    fill("evict40", 32'h0000_0040, 32'h1111_2222, 2);
    tick();
    fill("evict00", 32'h0000_0000, 32'h3401_1100, 1);

    // Flush while hitting: still a hit this cycle, miss next cycle.
    tick();
    pc_i = 32'h8; flush_i = 1'b1;
    #2;
    look("fl_hit", 32'h2403_0008, 1'b0, 1'b0);
    tick();
    flush_i = 1'b0;
    #2;
    look("fl_miss", 32'h0, 1'b1, 1'b0);
    // Flush while the request is out, ack a cycle later: fill discarded.
    tick();
    flush_i = 1'b1;
    #2;
    check("fl_req1", mem_req_o, 32'h1);
    check("fl_addr1", mem_addr_o, 32'h8);
    tick();
    flush_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    #2;
    check("fl_req2", mem_req_o, 32'h1);
    tick();
    mem_ack_i = 1'b0;
    #2;
    look("fl_nowrite", 32'h0, 1'b1, 1'b0);
    tick();
    #2;
    check("fl_rereq", mem_req_o, 32'h1);
    check("fl_readdr", mem_addr_o, 32'h8);
    // Flush on the very ack cycle: flush wins.
    tick();
    flush_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE_0008;
    #2;
    check("fl_ack_req", mem_req_o, 32'h1);
    // Flush in IDLE with a miss: no request raised.
    tick();
    flush_i = 1'b1; mem_ack_i = 1'b0;
    #2;
    look("fl_same", 32'h0, 1'b1, 1'b0);
    tick();
    flush_i = 1'b0;
    fill("fl_refill", 32'h8, 32'h2403_0008, 1);
    // Line 0 was wiped by the flushes.
    tick();
    fill("fl_line0", 32'h0, 32'h3401_1100, 2);

    // ce_i low on a valid line, with a stray ack in IDLE.
    tick();
    ce_i = 1'b0; pc_i = 32'h8; mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
    #2;
    look("ce0", 32'h0, 1'b0, 1'b0);
    tick();
    mem_ack_i = 1'b0;
    #2;
    look("ce0_noreq", 32'h0, 1'b0, 1'b0);
    tick();
    ce_i = 1'b1;
    #2;
    look("ce1_line8", 32'h2403_0008, 1'b0, 1'b0);
    tick();
    pc_i = 32'h0;
    #2;
    look("ce1_line0", 32'h3401_1100, 1'b0, 1'b0);

    // Async reset in the middle of a refill.
    tick();
    pc_i = 32'h44;
    #2;
    look("ar_miss", 32'h0, 1'b1, 1'b0);
    tick();
    #2;
    check("ar_req", mem_req_o, 32'h1);
    check("ar_addr", mem_addr_o, 32'h44);
    #1 rst = 1'b0;
    #1;
    look("ar_async", 32'h0, 1'b0, 1'b0);
    check("ar_async_addr", mem_addr_o, 32'h0);
    tick();
    tick();
    rst = 1'b1; pc_i = 32'h0;
    #2;
    look("ar_inv0", 32'h0, 1'b1, 1'b0);
    // pc moves during the refill; the latched address is what gets filled.
    tick();
    pc_i = 32'h4;
    #2;
    look("ar_inv4", 32'h0, 1'b1, 1'b1);
    check("ar_hold_addr", mem_addr_o, 32'h0);
    tick();
    pc_i = 32'h8; mem_ack_i = 1'b1; mem_rdata_i = 32'h3401_1100;
    #2;
    look("ar_inv8", 32'h0, 1'b1, 1'b1);
    tick();
    mem_ack_i = 1'b0; pc_i = 32'h0;
    #2;
    look("ar_fill0", 32'h3401_1100, 1'b0, 1'b0);
    tick();
    pc_i = 32'h8;
    #2;
    look("ar_still8", 32'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
